// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a 16-entry read FIFO popped over the register bus.
// Bit timing runs on clk from a programmable baud divider.
module uart_rx_fifo #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned PTR_W   = 5,
    parameter logic [7:0]  RX_ADDR = 8'h01
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              rx,
    input  logic [7:0]        baud_div,
    input  logic [7:0]        address,
    input  logic              FIFO_EN,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              rd_empty,
    output logic              rd_full,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int unsigned AW = PTR_W - 1;
    localparam int unsigned BW = $clog2(DATA_W);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              rx_m;
    logic              rx_s;
    logic [7:0]        cnt;
    logic [7:0]        half_div;
    logic [BW-1:0]     bit_idx;
    logic [DATA_W-1:0] shreg;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic bit_tick;
    logic shift_en;
    logic push_req;
    logic ferr_set;
    logic pop;
    logic push_ok;

    wire sync_clr = reset | clr;

    assign half_div = baud_div >> 1;

    // Two-flop synchroniser; idles high so reset never fakes a start bit
    always_ff @(posedge clk) begin
        if (sync_clr) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_clr) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!rx_s) state_nxt = START;
            START:   if (cnt == half_div) state_nxt = rx_s ? IDLE : DATA;
            DATA:    if (cnt == baud_div && bit_idx == BW'(DATA_W - 1)) state_nxt = STOP;
            STOP:    if (cnt == baud_div) state_nxt = rx_s ? IDLE : WAIT_HI;
            WAIT_HI: if (rx_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bit_tick = 1'b0;
        shift_en = 1'b0;
        push_req = 1'b0;
        ferr_set = 1'b0;
        case (state)
            START: bit_tick = (cnt == half_div);
            DATA: begin
                bit_tick = (cnt == baud_div);
                shift_en = (cnt == baud_div);
            end
            STOP: begin
                bit_tick = (cnt == baud_div);
                push_req = (cnt == baud_div) && rx_s;
                ferr_set = (cnt == baud_div) && !rx_s;
            end
            default: ;
        endcase
    end

    // Bit timer restarts on every state change and every sample point
    always_ff @(posedge clk) begin
        if (sync_clr) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (state_nxt != state || bit_tick) cnt <= '0;
            else if (state != IDLE)             cnt <= cnt + 8'd1;

            if (state == START && state_nxt == DATA) bit_idx <= '0;
            else if (shift_en)                       bit_idx <= bit_idx + BW'(1);

            if (shift_en) shreg <= {rx_s, shreg[DATA_W-1:1]};
        end
    end

    assign rd_empty = (wr_ptr == rd_ptr);
    assign rd_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign busy     = (state != IDLE);

    assign pop     = FIFO_EN && (address == RX_ADDR) && !rd_empty;
    assign push_ok = push_req && (!rd_full || pop);

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (sync_clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            data_valid <= pop;
            if (pop) begin
                data_out <= mem[rd_ptr[AW-1:0]];
                rd_ptr   <= rd_ptr + PTR_W'(1);
            end
            if (push_ok)                       wr_ptr    <= wr_ptr + PTR_W'(1);
            if (push_req && rd_full && !pop)   overrun   <= 1'b1;
            if (ferr_set)                      frame_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames are modelled when driven and
// compared when popped; flags are checked against the model occupancy.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       clr;
    logic       rx;
    logic [7:0] baud_div;
    logic [7:0] address;
    logic       fifo_en;
    logic [7:0] data_out;
    logic       data_valid;
    logic       rd_empty;
    logic       rd_full;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_out = 8'h00;
    bit         exp_ferr = 1'b0;
    bit         exp_ovr  = 1'b0;

    uart_rx_fifo dut (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr),
        .rx         (rx),
        .baud_div   (baud_div),
        .address    (address),
        .FIFO_EN    (fifo_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .rd_empty   (rd_empty),
        .rd_full    (rd_full),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_flags();
        check("rd_empty", 32'(rd_empty), 32'(exp_q.size() == 0));
        check("rd_full", 32'(rd_full), 32'(exp_q.size() == 16));
        check("frame_err", 32'(frame_err), 32'(exp_ferr));
        check("overrun", 32'(overrun), 32'(exp_ovr));
    endtask

    // Clock edge (counted from the edge before the start bit) on which the byte lands
    function automatic int push_edge();
        int b;
        b = int'(baud_div);
        return 3 + b / 2 + 1 + 9 * (b + 1);
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit good, input int stop_bits,
                              input bit pop_same);
        int bt;
        bt = int'(baud_div) + 1;
        if (good) begin
            if (exp_q.size() < 16 || pop_same) exp_q.push_back(b);
            else                               exp_ovr = 1'b1;
        end else begin
            exp_ferr = 1'b1;
        end
        rx = 1'b0;
        hold(bt);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            hold(bt);
        end
        rx = good;
        hold(bt * stop_bits);
        rx = 1'b1;
        hold(2 * bt);
    endtask

    task automatic do_pop(input logic [7:0] addr);
        bit         hit;
        logic [7:0] e;
        hit = (addr == 8'h01) && (exp_q.size() != 0);
        if (hit) e = exp_q.pop_front();
        else     e = last_out;
        address = addr;
        fifo_en = 1'b1;
        @(posedge clk);
        #1;
        fifo_en = 1'b0;
        address = 8'h00;
        check("data_valid", 32'(data_valid), 32'(hit));
        check("data_out", 32'(data_out), 32'(e));
        last_out = e;
        @(posedge clk);
        #1;
        check("dv_pulse", 32'(data_valid), 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_data_out", 32'(data_out), 32'h00);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check_flags();
    endtask

    initial begin
        reset    = 1'b1;
        clr      = 1'b0;
        rx       = 1'b1;
        fifo_en  = 1'b0;
        address  = 8'h00;
        baud_div = 8'd15;
        hold(3);
        reset = 1'b0;
        check_reset_outputs();

        // Single byte with exact push-cycle check, wrong-address and empty pops
        fork
            send_frame(8'hA5, 1'b1, 1, 1'b0);
            begin
                repeat (push_edge() - 1) @(posedge clk);
                #1;
                check("pre_push_empty", 32'(rd_empty), 32'd1);
                @(posedge clk);
                #1;
                check("post_push_empty", 32'(rd_empty), 32'd0);
            end
        join
        do_pop(8'h02);
        check_flags();
        do_pop(8'h01);
        check_flags();
        do_pop(8'h01);

        // Short low glitch: receiver starts, then abandons without a flag
        rx = 1'b0;
        hold(4);
        rx = 1'b1;
        hold(2);
        check("glitch_busy", 32'(busy), 32'd1);
        hold(30);
        check("glitch_idle", 32'(busy), 32'd0);
        check_flags();

        // Long-low stop bit, then a clean byte once the line is back high
        send_frame(8'h3C, 1'b0, 2, 1'b0);
        check("ferr_idle", 32'(busy), 32'd0);
        check_flags();
        send_frame(8'h81, 1'b1, 1, 1'b0);
        check_flags();
        do_pop(8'h01);

        // Minimum divider
        baud_div = 8'd3;
        send_frame(8'hC3, 1'b1, 1, 1'b0);
        do_pop(8'h01);
        baud_div = 8'd15;

        // Overfill by one
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1, 1, 1'b0);
            if (i >= 15) check_flags();
        end
        for (int i = 0; i < 16; i++) do_pop(8'h01);
        check_flags();

        clr = 1'b1;
        hold(1);
        clr = 1'b0;
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        check_flags();

        // Full FIFO: push and pop on the same edge
        for (int i = 0; i < 16; i++) send_frame(8'(8'h20 + i), 1'b1, 1, 1'b0);
        check_flags();
        fork
            send_frame(8'hEE, 1'b1, 1, 1'b1);
            begin
                repeat (push_edge() - 1) @(posedge clk);
                #1;
                do_pop(8'h01);
            end
        join
        check_flags();
        while (exp_q.size() != 0) do_pop(8'h01);
        check_flags();

        // Reset in the middle of a data bit, with an unread byte queued
        send_frame(8'h77, 1'b1, 1, 1'b0);
        rx = 1'b0;
        hold(16);
        rx = 1'b1;
        hold(16);
        rx = 1'b0;
        hold(16);
        check("mid_frame_busy", 32'(busy), 32'd1);
        rx    = 1'b1;
        reset = 1'b1;
        hold(1);
        reset = 1'b0;
        exp_q.delete();
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        last_out = 8'h00;
        check_reset_outputs();
        hold(32);
        send_frame(8'h66, 1'b1, 1, 1'b0);
        do_pop(8'h01);
        check_flags();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side counterpart of the UART TX FIFO. Deserialises an 8N1 serial stream on `rx` and buffers the received bytes in a 16-entry FIFO.
- The register-bus side reads the bytes using the same address/FIFO_EN decode style as the transmit path.
- Single clock domain. The bus and the bit-timing logic share `clk`.

Parameters:
- DATA_W, 8, data bits per frame and FIFO word width
- DEPTH, 16, FIFO entries (power of two)
- PTR_W, 5, pointer width = log2(DEPTH)+1; the extra MSB is the wrap bit
- RX_ADDR, 8'h01, bus address that selects a FIFO pop

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- clr  in  1  synchronous soft clear; same effect as reset
- rx  in  1  asynchronous serial input, idle high
- baud_div  in  8  bit period minus 1, in clk cycles; legal range 3..255
- address  in  8  bus address
- FIFO_EN  in  1  read strobe; qualified by address==RX_ADDR
- data_out  out  8  popped byte, registered
- data_valid  out  1  one-cycle pulse, data_out updated
- rd_empty  out  1  FIFO empty
- rd_full  out  1  FIFO full
- frame_err  out  1  sticky: stop bit sampled low
- overrun  out  1  sticky: byte dropped because FIFO full
- busy  out  1  receiver not in IDLE

Behaviour:
- Reset and clr:
  - Both are synchronous and share the same priority.
  - Outputs after reset: data_out=8'h00, data_valid=0, rd_empty=1, rd_full=0, frame_err=0, overrun=0, busy=0.
  - Internal state: pointers=0, FSM=IDLE, bit counter=0, synchroniser flops=1.
  - FIFO memory contents are not cleared.
  - Reset mid-frame discards the partial byte.
- Input synchroniser: `rx` passes through 2 flops to give rx_s. All FSM decisions use rx_s only.
- Bit timer: cnt (8b) increments each clk while not IDLE; cleared on every FSM transition and on each bit sample.
- FSM states: IDLE, START, DATA, STOP, WAIT_HI.
  - IDLE: when rx_s==0, go to START and set cnt=0.
  - START: when cnt==baud_div>>1 (mid start bit):
    - rx_s==0: go to DATA, cnt=0, bit index=0.
    - rx_s==1: glitch; return to IDLE with no flag.
  - DATA: when cnt==baud_div, shift rx_s into the shift register LSB-first and increment the bit index. After bit 7, go to STOP.
  - STOP: when cnt==baud_div, sample the stop bit:
    - rx_s==1: push the byte and go to IDLE.
    - rx_s==0: set frame_err, discard the byte, go to WAIT_HI.
  - WAIT_HI: stay until rx_s==1, then go to IDLE. This prevents a break condition being read as a new start bit.
- Push (STOP sample with rx_s==1):
  - The push occurs in the same cycle as the sample.
  - If the FIFO is full and no pop occurs that cycle, the byte is dropped and overrun is set. Pointers are unchanged.
  - Otherwise write mem[wr_ptr[3:0]] and increment wr_ptr.
- Pop: when FIFO_EN==1, address==RX_ADDR and rd_empty==0:
  - data_out<=mem[rd_ptr[3:0]], data_valid<=1, rd_ptr increments.
  - Pop while empty is ignored: data_valid=0 and data_out holds its value.
  - A non-matching address has no effect.
- Simultaneous push and pop:
  - Both take effect; occupancy is unchanged.
  - A push while full is accepted if a pop occurs in the same cycle.
  - A pop while empty never returns the same-cycle push (there is no fall-through). rd_empty deasserts the next cycle.
- Flags:
  - rd_empty = (wr_ptr==rd_ptr); derived combinationally from the registered pointers.
  - rd_full = (low PTR_W-1 bits equal) && (MSBs differ).
  - Pointers wrap modulo 2*DEPTH.
  - frame_err and overrun are sticky and clear only on reset or clr.
- busy = FSM != IDLE.
- Latency: with baud_div=B, the push occurs B/2+1 + 9*(B+1) cycles after rx_s first reads 0. The rx-pin-to-rx_s delay is 2 cycles.

Test Plan:
- baud_div=15; send 0xA5 with a valid stop bit -> rd_empty falls; pop at address 0x01 -> data_out=0xA5, data_valid high for 1 cycle, rd_empty=1.
- Low glitch on rx of 4 clk (baud_div=15) -> FSM returns to IDLE from START; no push, frame_err=0.
- Send 0x3C with the stop bit held low for 2 bit times -> frame_err=1, FIFO empty; the next valid 0x81 is received correctly once rx returns high.
- Send 17 bytes 0x00..0x10 with no pops -> rd_full=1 after 16 bytes, overrun=1, pops return 0x00..0x0F in order, then rd_empty=1.
- With the FIFO full, complete a stop bit in the same cycle as a pop -> both occur, rd_full stays 1, overrun stays 0.
- Assert reset during DATA of byte 0x55, then send 0x66 -> only 0x66 is popped; all outputs are at their reset values on the cycle after reset.
